cmd_queue: RTL and testbench

- Command FIFO directly upstream of the issuer in top.
- Buffers cmd_t words pushed by the host/loader.
- Presents the head command combinationally on o_cmd (first-word-fall-through) with an o_empty flag; the issuer consumes it with a one-cycle read strobe.
- Replaces the behavioural queue the system bench currently drives by hand.

---
 rtl/cmd_queue_pkg.sv | 17 +
 rtl/cmd_queue_mem.sv | 23 ++
 rtl/cmd_queue.sv | 146 ++++++++++++++
 tb/tb_cmd_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_queue_pkg.sv
// Shared command definitions used by the issuer and the command queue.
// Provides cmd_t, its packed width CMD_W, and a saturating counter helper.
package cmd_queue_pkg;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] arg;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/cmd_queue_mem.sv
// Command storage: DEPTH x W array, one synchronous write port and one
// asynchronous read port. The array is intentionally not reset.
module cmd_queue_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/cmd_queue.sv
// First-word-fall-through command FIFO feeding the issuer.
// Define CMD_QUEUE_STATS_EN to add push/pop counters and a high-water mark.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [CMD_W-1:0]         i_cmd,
  output logic                     o_full,
  output logic                     o_almost_full,
  input  logic                     i_rd,
  output logic [CMD_W-1:0]         o_cmd,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [31:0]              o_push_cnt,
  output logic [31:0]              o_pop_cnt,
  output logic [$clog2(DEPTH):0]   o_high_water
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic empty, full, push_ok, pop_ok, mem_we;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // A full queue still takes a push when the same cycle frees the head slot.
  assign pop_ok  = i_rd && !empty;
  assign push_ok = i_wr && (!full || pop_ok);
  assign mem_we  = push_ok && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (i_wr && !push_ok) ovf_d = 1'b1;
      if (i_rd && !pop_ok)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  cmd_queue_mem #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_cmd),
    .i_raddr (rd_ptr_q),
    .o_rdata (o_cmd)
  );

  assign o_empty       = empty;
  assign o_full        = full;
  assign o_almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign o_count       = count_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

`ifdef CMD_QUEUE_STATS_EN
  logic [31:0]      push_cnt_q, push_cnt_d;
  logic [31:0]      pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0] high_water_q, high_water_d;

  // High water tracks the post-edge count so it never lags o_count.
  always_comb begin
    push_cnt_d   = push_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    high_water_d = high_water_q;
    if (i_flush) begin
      push_cnt_d   = '0;
      pop_cnt_d    = '0;
      high_water_d = '0;
    end else begin
      push_cnt_d = sat_inc32(push_cnt_q, push_ok);
      pop_cnt_d  = sat_inc32(pop_cnt_q, pop_ok);
      if (count_d > high_water_q) high_water_d = count_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      push_cnt_q   <= '0;
      pop_cnt_q    <= '0;
      high_water_q <= '0;
    end else begin
      push_cnt_q   <= push_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      high_water_q <= high_water_d;
    end
  end

  assign o_push_cnt   = push_cnt_q;
  assign o_pop_cnt    = pop_cnt_q;
  assign o_high_water = high_water_q;
`endif

endmodule

// File: tb/tb_cmd_queue.sv
// Directed bench for cmd_queue with DEPTH=4, AF_LEVEL=2.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AF    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, flush, wr, rd;
  logic [CMD_W-1:0] cmd_in;
  logic             full, afull, empty, ovf, unf;
  logic [CMD_W-1:0] cmd_out;
  logic [CW-1:0]    count;
`ifdef CMD_QUEUE_STATS_EN
  logic [31:0]      push_cnt, pop_cnt;
  logic [CW-1:0]    high_water;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmd_queue #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_wr          (wr),
    .i_cmd         (cmd_in),
    .o_full        (full),
    .o_almost_full (afull),
    .i_rd          (rd),
    .o_cmd         (cmd_out),
    .o_empty       (empty),
    .o_count       (count),
    .o_overflow    (ovf),
    .o_underflow   (unf)
`ifdef CMD_QUEUE_STATS_EN
    ,
    .o_push_cnt    (push_cnt),
    .o_pop_cnt     (pop_cnt),
    .o_high_water  (high_water)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_afull"}, 32'(afull), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ovf"},   32'(ovf),   32'd0);
    chk({tag, "_unf"},   32'(unf),   32'd0);
  endtask

  logic [CMD_W-1:0] exp_q[$];

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; cmd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    tick();

    // Push A, B, C
    wr = 1'b1; cmd_in = 16'hA00A; tick();
    chk("a_empty", 32'(empty), 32'd0);
    chk("a_head",  32'(cmd_out), 32'hA00A);
    chk("a_count", 32'(count), 32'd1);
    chk("a_afull", 32'(afull), 32'd0);
    cmd_in = 16'hB00B; tick();
    chk("b_count", 32'(count), 32'd2);
    chk("b_afull", 32'(afull), 32'd1);
    chk("b_head",  32'(cmd_out), 32'hA00A);
    cmd_in = 16'hC00C; tick();
    chk("c_count", 32'(count), 32'd3);
    chk("c_full",  32'(full),  32'd0);

    // Fill with D, then E overflows
    cmd_in = 16'hD00D; tick();
    chk("d_count", 32'(count), 32'd4);
    chk("d_full",  32'(full),  32'd1);
    chk("d_ovf",   32'(ovf),   32'd0);
    cmd_in = 16'hE00E; tick();
    chk("e_count", 32'(count), 32'd4);
    chk("e_full",  32'(full),  32'd1);
    chk("e_ovf",   32'(ovf),   32'd1);
    wr = 1'b0;
    exp_q = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D};
    foreach (exp_q[i]) begin
      chk("drain1_head", 32'(cmd_out), 32'(exp_q[i]));
      rd = 1'b1; tick();
    end
    rd = 1'b0;
    chk("drain1_empty", 32'(empty), 32'd1);
    chk("drain1_count", 32'(count), 32'd0);
    chk("drain1_ovf",   32'(ovf),   32'd1);
    chk("drain1_unf",   32'(unf),   32'd0);

    // Full queue, simultaneous push F and pop
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wr = 1'b1;
    foreach (exp_q[i]) begin
      cmd_in = exp_q[i]; tick();
    end
    chk("fp_full_pre", 32'(full), 32'd1);
    chk("fp_head_pre", 32'(cmd_out), 32'h1111);
    cmd_in = 16'hF00F; rd = 1'b1; tick();
    wr = 1'b0; rd = 1'b0;
    chk("fp_count", 32'(count), 32'd4);
    chk("fp_full",  32'(full),  32'd1);
    exp_q = '{16'h2222, 16'h3333, 16'h4444, 16'hF00F};
    foreach (exp_q[i]) begin
      chk("drain2_head", 32'(cmd_out), 32'(exp_q[i]));
      rd = 1'b1; tick();
    end
    rd = 1'b0;
    chk("drain2_empty", 32'(empty), 32'd1);
    chk("drain2_unf",   32'(unf),   32'd0);

    // Empty queue, simultaneous pop and push G
    wr = 1'b1; rd = 1'b1; cmd_in = 16'h6006; tick();
    idle_inputs();
    chk("g_unf",   32'(unf),   32'd1);
    chk("g_count", 32'(count), 32'd1);
    chk("g_empty", 32'(empty), 32'd0);
    chk("g_head",  32'(cmd_out), 32'h6006);

    // Flush with three entries and sticky flags set; same-cycle push dropped
    wr = 1'b1; cmd_in = 16'h7007; tick();
    cmd_in = 16'h8008; tick();
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; cmd_in = 16'hDEAD; tick();
    idle_inputs();
    check_reset_state("flush");
    tick();
    chk("flush_hold_count", 32'(count), 32'd0);
    wr = 1'b1; cmd_in = 16'h9009; tick();
    wr = 1'b0;
    chk("post_flush_head",  32'(cmd_out), 32'h9009);
    chk("post_flush_count", 32'(count), 32'd1);
    rd = 1'b1; tick();
    rd = 1'b0;
    chk("post_flush_empty", 32'(empty), 32'd1);

    // Streaming push+pop: 10 words, pointers wrap twice
    wr = 1'b1; cmd_in = 16'h0100; tick();
    chk("stream_head0", 32'(cmd_out), 32'h0100);
    rd = 1'b1;
    for (int i = 1; i < 10; i++) begin
      cmd_in = 16'h0100 + 16'(i); tick();
      chk("stream_head",  32'(cmd_out), 32'h0100 + 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    chk("stream_unf", 32'(unf), 32'd0);
`ifdef CMD_QUEUE_STATS_EN
    chk("hw_pre_rst",   32'(high_water), 32'd1);
    chk("push_pre_rst", push_cnt, 32'd11);
`endif

    // Asynchronous reset mid-cycle, no clock edge in between
    cmd_in = 16'h0200;
    #3 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
`ifdef CMD_QUEUE_STATS_EN
    chk("rst_push_cnt", push_cnt, 32'd0);
    chk("rst_pop_cnt",  pop_cnt,  32'd0);
    chk("rst_hw",       32'(high_water), 32'd0);
`endif
    idle_inputs();
    tick();
    rst = 1'b0;
    wr = 1'b1; cmd_in = 16'h0A0A; tick();
    wr = 1'b0;
    chk("after_rst_head",  32'(cmd_out), 32'h0A0A);
    chk("after_rst_count", 32'(count), 32'd1);
    chk("after_rst_empty", 32'(empty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
